alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 11 +
 rtl/alu_arbiter_if.sv | 36 +++
 rtl/rr_arbiter2.sv | 12 +
 rtl/alu_arbiter.sv | 88 ++++++++
 tb/tb_alu_arbiter.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants, FSM encoding and defaults shared by the ALU arbiter
package alu_pkg;
    localparam logic [3:0] OP_SINGLE0 = 4'd4;
    localparam logic [3:0] OP_SINGLE1 = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd12;
    localparam int MUL_TIMEOUT_DEF = 12;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ALU = 2'd1, S_MUL = 2'd2, S_RESP = 2'd3} state_t;
    function automatic logic is_single(input logic [3:0] op);
        return op == OP_SINGLE0 || op == OP_SINGLE1;
    endfunction
endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester, datapath and response signals of the ALU arbiter
interface alu_arbiter_if;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [3:0] req0_opcode;
    logic [3:0] req1_opcode;
    logic [7:0] req0_opA;
    logic [7:0] req1_opA;
    logic [7:0] req0_opB;
    logic [7:0] req1_opB;
    logic enAlu;
    logic enMul;
    logic [3:0] opcode_o;
    logic [7:0] opA_o;
    logic [7:0] opB_o;
    logic [15:0] res_in;
    logic mul_done;
    logic [1:0] rsp_valid;
    logic [1:0] rsp_ready;
    logic [15:0] rsp_data;
    logic rsp_err;
    logic busy;
    logic [1:0] state;
    modport slave (
        input req_valid, req0_opcode, req1_opcode, req0_opA, req1_opA, req0_opB, req1_opB,
        input res_in, mul_done, rsp_ready,
        output req_ready, enAlu, enMul, opcode_o, opA_o, opB_o, rsp_valid, rsp_data, rsp_err,
        output busy, state
    );
    modport master (
        output req_valid, req0_opcode, req1_opcode, req0_opA, req1_opA, req0_opB, req1_opB,
        output res_in, mul_done, rsp_ready,
        input req_ready, enAlu, enMul, opcode_o, opA_o, opB_o, rsp_valid, rsp_data, rsp_err,
        input busy, state
    );
endinterface

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin pick; the requester not granted last time wins a tie
module rr_arbiter2 (
    input logic [1:0] req,
    input logic last,
    output logic [1:0] grant,
    output logic id
);
    always_comb begin
        grant = (&req) ? (last ? 2'b01 : 2'b10) : req;
        id = grant[1];
    end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU/multiplier datapath between two requesters
module alu_arbiter
    import alu_pkg::*;
#(
    parameter logic [3:0] MUL_OPCODE = OP_MUL,
    parameter int MUL_TIMEOUT = MUL_TIMEOUT_DEF
) (
    input logic clock,
    input logic reset,
    alu_arbiter_if.slave bus
);
    localparam int CW = $clog2(MUL_TIMEOUT + 1);
    state_t st, st_nxt;
    logic [1:0] grant;
    logic gid, acc, last, lat_g, timeout;
    logic [3:0] lat_op, op_sel;
    logic [7:0] lat_a, lat_b, a_sel, b_sel;
    logic [CW-1:0] cnt;
    logic [15:0] data_r;
    logic err_r;
    rr_arbiter2 u_rr (.req(bus.req_valid), .last(last), .grant(grant), .id(gid));
    always_comb begin
        op_sel = gid ? bus.req1_opcode : bus.req0_opcode;
        a_sel = gid ? bus.req1_opA : bus.req0_opA;
        b_sel = gid ? bus.req1_opB : bus.req0_opB;
        acc = st == S_IDLE && |(bus.req_valid & grant);
        timeout = cnt == CW'(MUL_TIMEOUT);
    end
    always_ff @(posedge clock) begin
        if (reset) st <= S_IDLE;
        else st <= st_nxt;
    end
    always_comb begin
        st_nxt = st == S_IDLE ? (acc ? (op_sel == MUL_OPCODE ? S_MUL : S_ALU) : S_IDLE)
               : st == S_ALU  ? S_RESP
               : st == S_MUL  ? ((bus.mul_done || timeout) ? S_RESP : S_MUL)
               : (bus.rsp_ready[lat_g] ? S_IDLE : S_RESP);
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            lat_op <= '0;
            lat_a <= '0;
            lat_b <= '0;
            lat_g <= 1'b0;
            last <= 1'b1;
            cnt <= '0;
            data_r <= '0;
            err_r <= 1'b0;
        end else begin
            if (acc) begin
                lat_op <= op_sel;
                lat_a <= a_sel;
                lat_b <= is_single(op_sel) ? 8'h00 : b_sel;
                lat_g <= gid;
                cnt <= CW'(1);
            end
            if (st == S_ALU) begin
                data_r <= bus.res_in;
                err_r <= 1'b0;
            end
            // mul_done takes priority over a timeout landing on the same cycle
            if (st == S_MUL) begin
                cnt <= cnt + 1'b1;
                if (bus.mul_done) begin
                    data_r <= bus.res_in;
                    err_r <= 1'b0;
                end else if (timeout) begin
                    data_r <= '0;
                    err_r <= 1'b1;
                end
            end
            if (st == S_RESP && bus.rsp_ready[lat_g]) last <= lat_g;
        end
    end
    always_comb begin
        bus.req_ready = (st == S_IDLE && !reset) ? grant : 2'b00;
        bus.enAlu = st == S_ALU;
        bus.enMul = st == S_MUL;
        bus.opcode_o = st == S_ALU ? lat_op : st == S_MUL ? MUL_OPCODE : 4'h0;
        bus.opA_o = (st == S_ALU || st == S_MUL) ? lat_a : 8'h00;
        bus.opB_o = (st == S_ALU || st == S_MUL) ? lat_b : 8'h00;
        bus.rsp_valid = st == S_RESP ? (lat_g ? 2'b10 : 2'b01) : 2'b00;
        bus.rsp_data = data_r;
        bus.rsp_err = err_r;
        bus.busy = st != S_IDLE;
        bus.state = st;
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scenarios with hand-computed expectations for alu_arbiter
module tb_alu_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int vectors = 0;
    int errs = 0;
    logic [45:0] outs;
    alu_arbiter_if bus();
    alu_arbiter #(.MUL_OPCODE(4'd12), .MUL_TIMEOUT(12)) dut (.clock(clock), .reset(reset), .bus(bus));
    always #5 clock = ~clock;
    assign outs = {bus.req_ready, bus.enAlu, bus.enMul, bus.opcode_o, bus.opA_o, bus.opB_o,
                   bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.busy, bus.state};

    task automatic idle_inputs();
        bus.req_valid = 2'b00;
        bus.req0_opcode = 4'h0;
        bus.req1_opcode = 4'h0;
        bus.req0_opA = 8'h00;
        bus.req1_opA = 8'h00;
        bus.req0_opB = 8'h00;
        bus.req1_opB = 8'h00;
        bus.res_in = 16'h0000;
        bus.mul_done = 1'b0;
        bus.rsp_ready = 2'b00;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        bus.req_valid = 2'b11;
        bus.mul_done = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        vectors++; if (outs !== 46'h0) begin errs++; $display("FAIL reset_outputs: got %h want 0", outs); end
        reset = 1'b0;
        bus.req_valid = 2'b00;
        bus.mul_done = 1'b0;
        @(negedge clock);
        #1;
        vectors++; if (outs !== 46'h0) begin errs++; $display("FAIL idle_after_reset: got %h want 0", outs); end
    endtask

    task automatic test_alu_single();
        bus.req_valid = 2'b01;
        bus.req0_opcode = 4'd1;
        bus.req0_opA = 8'h05;
        bus.req0_opB = 8'h03;
        #1;
        vectors++; if (bus.req_ready !== 2'b01) begin errs++; $display("FAIL s1_ready: got %b want 01", bus.req_ready); end
        @(negedge clock);
        bus.req_valid = 2'b00;
        bus.res_in = 16'h0008;
        #1;
        vectors++; if ({bus.enAlu, bus.enMul, bus.state, bus.opcode_o, bus.opA_o, bus.opB_o} !== {1'b1, 1'b0, 2'd1, 4'd1, 8'h05, 8'h03}) begin
            errs++; $display("FAIL s1_alu_cycle: got en=%b%b st=%0d op=%h a=%h b=%h want en=10 st=1 op=1 a=05 b=03",
                             bus.enAlu, bus.enMul, bus.state, bus.opcode_o, bus.opA_o, bus.opB_o); end
        @(negedge clock);
        #1;
        vectors++; if ({bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.enAlu} !== {2'b01, 16'h0008, 1'b0, 1'b0}) begin
            errs++; $display("FAIL s1_resp: got v=%b d=%h e=%b en=%b want v=01 d=0008 e=0 en=0",
                             bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.enAlu); end
        bus.rsp_ready = 2'b01;
        @(negedge clock);
        #1;
        vectors++; if ({bus.state, bus.rsp_valid, bus.busy} !== {2'd0, 2'b00, 1'b0}) begin
            errs++; $display("FAIL s1_back_idle: got st=%0d v=%b busy=%b want st=0 v=00 busy=0", bus.state, bus.rsp_valid, bus.busy); end
        bus.rsp_ready = 2'b00;
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_oh;
        do_reset();
        bus.req_valid = 2'b11;
        bus.req0_opcode = 4'd2;
        bus.req0_opA = 8'h11;
        bus.req0_opB = 8'h01;
        bus.req1_opcode = 4'd3;
        bus.req1_opA = 8'h22;
        bus.req1_opB = 8'h02;
        bus.rsp_ready = 2'b11;
        for (int i = 0; i < 4; i++) begin
            exp_oh = (i % 2 == 1) ? 2'b10 : 2'b01;
            #1;
            vectors++; if (bus.req_ready !== exp_oh) begin errs++; $display("FAIL b2b_grant%0d: got %b want %b", i, bus.req_ready, exp_oh); end
            @(negedge clock);
            bus.res_in = 16'h0100 + 16'(i);
            #1;
            vectors++; if (bus.opA_o !== (exp_oh[1] ? 8'h22 : 8'h11) || bus.enAlu !== 1'b1) begin
                errs++; $display("FAIL b2b_opA%0d: got a=%h en=%b want a=%h en=1", i, bus.opA_o, bus.enAlu, exp_oh[1] ? 8'h22 : 8'h11); end
            @(negedge clock);
            #1;
            vectors++; if (bus.rsp_valid !== exp_oh || bus.rsp_data !== 16'h0100 + 16'(i)) begin
                errs++; $display("FAIL b2b_resp%0d: got v=%b d=%h want v=%b d=%h", i, bus.rsp_valid, bus.rsp_data, exp_oh, 16'h0100 + 16'(i)); end
            @(negedge clock);
        end
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b00;
    endtask

    task automatic test_mul_done();
        int n = 0;
        bus.req_valid = 2'b10;
        bus.req1_opcode = 4'd12;
        bus.req1_opA = 8'h0F;
        bus.req1_opB = 8'h0A;
        #1;
        vectors++; if (bus.req_ready !== 2'b10) begin errs++; $display("FAIL s3_ready: got %b want 10", bus.req_ready); end
        @(negedge clock);
        bus.req_valid = 2'b00;
        for (int c = 0; c < 40 && bus.enMul === 1'b1; c++) begin
            n++;
            if (n == 1) begin
                vectors++; if ({bus.opcode_o, bus.opA_o, bus.opB_o} !== {4'd12, 8'h0F, 8'h0A}) begin
                    errs++; $display("FAIL s3_mul_operands: got op=%h a=%h b=%h want op=c a=0f b=0a", bus.opcode_o, bus.opA_o, bus.opB_o); end
            end
            if (n == 8) begin
                bus.mul_done = 1'b1;
                bus.res_in = 16'h0096;
            end
            @(negedge clock);
            #1;
        end
        vectors++; if (n !== 8) begin errs++; $display("FAIL s3_mul_cycles: got %0d want 8", n); end
        vectors++; if ({bus.rsp_valid, bus.rsp_data, bus.rsp_err} !== {2'b10, 16'h0096, 1'b0}) begin
            errs++; $display("FAIL s3_resp: got v=%b d=%h e=%b want v=10 d=0096 e=0", bus.rsp_valid, bus.rsp_data, bus.rsp_err); end
        bus.mul_done = 1'b0;
        bus.rsp_ready = 2'b10;
        @(negedge clock);
        #1;
        vectors++; if (bus.state !== 2'd0) begin errs++; $display("FAIL s3_back_idle: got %0d want 0", bus.state); end
        bus.rsp_ready = 2'b00;
    endtask

    task automatic test_mul_timeout();
        int n = 0;
        bus.mul_done = 1'b1;
        bus.res_in = 16'hFFFF;
        @(negedge clock);
        #1;
        vectors++; if ({bus.state, bus.rsp_valid, bus.rsp_data} !== {2'd0, 2'b00, 16'h0096}) begin
            errs++; $display("FAIL done_ignored_idle: got st=%0d v=%b d=%h want st=0 v=00 d=0096", bus.state, bus.rsp_valid, bus.rsp_data); end
        bus.mul_done = 1'b0;
        bus.req_valid = 2'b01;
        bus.req0_opcode = 4'd12;
        bus.req0_opA = 8'h07;
        bus.req0_opB = 8'h09;
        #1;
        vectors++; if (bus.req_ready !== 2'b01) begin errs++; $display("FAIL s4_ready: got %b want 01", bus.req_ready); end
        @(negedge clock);
        bus.req_valid = 2'b11;
        #1;
        for (int c = 0; c < 40 && bus.enMul === 1'b1; c++) begin
            n++;
            if (n == 1) begin
                vectors++; if (bus.req_ready !== 2'b00) begin errs++; $display("FAIL s4_no_accept_busy: got %b want 00", bus.req_ready); end
            end
            if (n == 5) bus.req_valid = 2'b00;
            @(negedge clock);
            #1;
        end
        vectors++; if (n !== 12) begin errs++; $display("FAIL s4_mul_cycles: got %0d want 12", n); end
        vectors++; if ({bus.rsp_valid, bus.rsp_data, bus.rsp_err} !== {2'b01, 16'h0000, 1'b1}) begin
            errs++; $display("FAIL s4_resp: got v=%b d=%h e=%b want v=01 d=0000 e=1", bus.rsp_valid, bus.rsp_data, bus.rsp_err); end
        bus.rsp_ready = 2'b10;
        @(negedge clock);
        #1;
        vectors++; if ({bus.state, bus.rsp_valid} !== {2'd3, 2'b01}) begin
            errs++; $display("FAIL s4_wrong_ready: got st=%0d v=%b want st=3 v=01", bus.state, bus.rsp_valid); end
        bus.rsp_ready = 2'b01;
        @(negedge clock);
        #1;
        vectors++; if (bus.state !== 2'd0) begin errs++; $display("FAIL s4_back_idle: got %0d want 0", bus.state); end
        bus.rsp_ready = 2'b00;
    endtask

    task automatic test_single_stall();
        bus.req_valid = 2'b10;
        bus.req1_opcode = 4'd4;
        bus.req1_opA = 8'h3C;
        bus.req1_opB = 8'hFF;
        #1;
        vectors++; if (bus.req_ready !== 2'b10) begin errs++; $display("FAIL s5_ready: got %b want 10", bus.req_ready); end
        @(negedge clock);
        bus.req_valid = 2'b00;
        bus.res_in = 16'hABCD;
        #1;
        vectors++; if ({bus.enAlu, bus.opcode_o, bus.opA_o, bus.opB_o} !== {1'b1, 4'd4, 8'h3C, 8'h00}) begin
            errs++; $display("FAIL s5_opB_zero: got en=%b op=%h a=%h b=%h want en=1 op=4 a=3c b=00", bus.enAlu, bus.opcode_o, bus.opA_o, bus.opB_o); end
        @(negedge clock);
        for (int i = 0; i < 5; i++) begin
            bus.res_in = 16'(i);
            #1;
            vectors++; if ({bus.rsp_valid, bus.rsp_data, bus.rsp_err} !== {2'b10, 16'hABCD, 1'b0}) begin
                errs++; $display("FAIL s5_stall%0d: got v=%b d=%h e=%b want v=10 d=abcd e=0", i, bus.rsp_valid, bus.rsp_data, bus.rsp_err); end
            @(negedge clock);
        end
        bus.rsp_ready = 2'b10;
        @(negedge clock);
        #1;
        vectors++; if (bus.state !== 2'd0) begin errs++; $display("FAIL s5_back_idle: got %0d want 0", bus.state); end
        for (int i = 0; i < 2; i++) begin
            bus.req_valid = 2'b01;
            bus.req0_opcode = (i == 0) ? 4'd7 : 4'd5;
            bus.req0_opA = 8'h66;
            bus.req0_opB = 8'h55;
            bus.rsp_ready = 2'b01;
            @(negedge clock);
            bus.req_valid = 2'b00;
            #1;
            vectors++; if (bus.opB_o !== ((i == 0) ? 8'h00 : 8'h55)) begin
                errs++; $display("FAIL opB_op%0d: got %h want %h", (i == 0) ? 7 : 5, bus.opB_o, (i == 0) ? 8'h00 : 8'h55); end
            repeat (2) @(negedge clock);
        end
        bus.rsp_ready = 2'b00;
    endtask

    task automatic test_reset_mid_mul();
        bus.req_valid = 2'b01;
        bus.req0_opcode = 4'd1;
        bus.rsp_ready = 2'b01;
        @(negedge clock);
        bus.req_valid = 2'b00;
        repeat (2) @(negedge clock);
        bus.rsp_ready = 2'b00;
        bus.req_valid = 2'b10;
        bus.req1_opcode = 4'd12;
        @(negedge clock);
        bus.req_valid = 2'b00;
        repeat (2) @(negedge clock);
        #1;
        vectors++; if (bus.state !== 2'd2) begin errs++; $display("FAIL s6_in_mul: got %0d want 2", bus.state); end
        reset = 1'b1;
        @(negedge clock);
        #1;
        vectors++; if (outs !== 46'h0) begin errs++; $display("FAIL s6_reset_outputs: got %h want 0", outs); end
        reset = 1'b0;
        bus.req_valid = 2'b11;
        bus.req0_opcode = 4'd1;
        bus.req1_opcode = 4'd1;
        #1;
        vectors++; if (bus.req_ready !== 2'b01) begin errs++; $display("FAIL s6_post_reset_grant: got %b want 01", bus.req_ready); end
        @(negedge clock);
        bus.req_valid = 2'b00;
        repeat (2) @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        test_reset();
        test_alu_single();
        test_back_to_back();
        test_mul_done();
        test_mul_timeout();
        test_single_stall();
        test_reset_mid_mul();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
